dsp_mem_loader: RTL

Stream-to-memory write engine directly upstream of the per-channel DSP units. Accepts a 32-bit valid/ready word stream from the host interconnect, decodes a burst header, and drives the `mem_write_addr` / `mem_write_data` / `mem_write_en` write port of one of `N_CORES` DSP units. It emits one write per data beat with address auto-increment, so command and envelope memories load at one word per cycle.

---
 rtl/dsp_loader_pkg.sv | 46 ++++
 rtl/dsp_mem_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_loader_pkg.sv
// -----------------------------------------------------------------------------
// dsp_loader_pkg
// Shared definitions for the DSP memory loader:
//   - bit positions of the burst header fields
//   - indices of the sticky error flags
//   - loader FSM state encoding
//   - hdr_decode(): splits a 32-bit header word into its fields
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package dsp_loader_pkg;

  // Header word layout. Bits [15:13] are reserved and ignored.
  localparam int HDR_CSEL_MSB = 31;
  localparam int HDR_CSEL_LSB = 29;
  localparam int HDR_CNT_MSB  = 28;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_ADDR_MSB = 12;
  localparam int HDR_ADDR_LSB = 0;

  // Sticky error flag indices.
  localparam int ERR_CSEL  = 0;  // core select out of range
  localparam int ERR_OVF   = 1;  // address ran past the top of the memory
  localparam int ERR_FRAME = 2;  // s_last placement disagrees with the count

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_DRAIN
  } loader_state_t;

  typedef struct packed {
    logic [2:0]  csel;  // target DSP unit
    logic [12:0] cnt;   // word count minus one
    logic [12:0] base;  // first write address
  } hdr_t;

  function automatic hdr_t hdr_decode(input logic [31:0] word);
    hdr_t h;
    h.csel = word[HDR_CSEL_MSB:HDR_CSEL_LSB];
    h.cnt  = word[HDR_CNT_MSB:HDR_CNT_LSB];
    h.base = word[HDR_ADDR_MSB:HDR_ADDR_LSB];
    return h;
  endfunction

endpackage

// File: rtl/dsp_mem_loader.sv
// -----------------------------------------------------------------------------
// dsp_mem_loader
// Turns a valid/ready word stream (header + data beats) into single-cycle
// writes on the write port of one of N_CORES DSP units, with address
// auto-increment. All write-port outputs are registered: a beat accepted on
// edge k appears on mem_write_* after edge k.
//
// Ports:
//   clk             clock
//   reset           asynchronous reset, active low
//   s_data          stream word (header or data)
//   s_valid         stream word valid
//   s_last          final word of a burst
//   s_ready         loader accepts s_data (always 1 out of reset)
//   abort           drop the burst in progress (synchronous)
//   mem_write_addr  write address, shared by all cores
//   mem_write_data  write data, shared by all cores
//   mem_write_en    one-hot per-core write strobe
//   busy            header accepted, burst not yet ended
//   done            one-cycle pulse at burst end (normal or error)
//   err             sticky flags {framing, addr overflow, bad core select}
//   err_clr         clear err (a same-cycle new error still sets its flag)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dsp_mem_loader
  import dsp_loader_pkg::*;
#(
  parameter int N_CORES    = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [N_CORES-1:0]    mem_write_en,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            err,
  input  logic                  err_clr
);

  loader_state_t         state_q, state_d;
  // One extra bit so an address past the top is detectable instead of wrapping.
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [12:0]           rem_q, rem_d;      // beats remaining minus one
  logic [2:0]            core_q, core_d;
  logic                  core_ok_q, core_ok_d;
  logic [N_CORES-1:0]    we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2:0]            err_q, err_d;

  logic       beat;
  logic       wr;
  logic       csel_ok;
  logic [2:0] err_set;
  hdr_t       hdr;

  // The loader never stalls, so it is ready whenever reset is released.
  assign s_ready = reset;
  assign beat    = s_valid & s_ready;
  assign hdr     = hdr_decode(s_data[31:0]);
  assign csel_ok = int'(hdr.csel) < N_CORES;

  // NOTE: every variable gets a default at the top of the block so that no
  // path through the case statement leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    core_d    = core_q;
    core_ok_d = core_ok_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_set   = '0;
    wr        = 1'b0;

    if (abort) begin
      // Abort outranks any beat in the same cycle; that beat is dropped.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = busy_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (beat) begin
            if (s_last) begin
              // A header alone is not a burst.
              err_set[ERR_FRAME] = 1'b1;
              done_d             = 1'b1;
            end else begin
              core_d            = hdr.csel;
              core_ok_d         = csel_ok;
              err_set[ERR_CSEL] = ~csel_ok;
              addr_d            = (ADDR_WIDTH + 1)'(hdr.base);
              rem_d             = hdr.cnt;
              busy_d            = 1'b1;
              state_d           = ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (beat) begin
            wr = core_ok_q & ~addr_q[ADDR_WIDTH];
            // Once past the top the address freezes there, so it never wraps.
            if (addr_q[ADDR_WIDTH]) err_set[ERR_OVF] = 1'b1;
            else                    addr_d = addr_q + 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == '0) begin
              if (s_last) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
              end else begin
                err_set[ERR_FRAME] = 1'b1;
                state_d            = ST_DRAIN;
              end
            end else if (s_last) begin
              // Truncated burst: this beat is still written.
              err_set[ERR_FRAME] = 1'b1;
              done_d             = 1'b1;
              busy_d             = 1'b0;
              state_d            = ST_IDLE;
            end
          end
        end

        ST_DRAIN: begin
          if (beat && s_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    if (wr) begin
      waddr_d = addr_q[ADDR_WIDTH-1:0];
      wdata_d = s_data;
    end

    for (int i = 0; i < N_CORES; i++) begin
      we_d[i] = wr && (core_q == 3'(i));
    end

    // New error events win over a same-cycle clear.
    err_d = (err_clr ? 3'b000 : err_q) | err_set;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      core_q    <= '0;
      core_ok_q <= 1'b0;
      we_q      <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      core_q    <= core_d;
      core_ok_q <= core_ok_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mem_write_en   = we_q;
  assign mem_write_addr = waddr_q;
  assign mem_write_data = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
